mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store unit of the rv32i pipeline, between the EX/MEM pipeline register and the MEM/WB register (`stage_memwb`). It does the following:
- Drives a req/ack data-bus handshake.
- Generates byte strobes and aligns store data.
- Extracts and sign/zero-extends load data.
- Stalls the upstream pipeline until the access completes.

Non-memory instructions pass through with zero latency.

## Interface
Parameters:
- DATA_WIDTH, 32, data/address width
- RADDR_WIDTH, 5, register-index width
- TIMEOUT_CYCLES, 256, bus timeout limit (used only with DBUS_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_read_i / mem_write_i  in  1  load / store request from EX/MEM
- funct3_i  in  3  access size/sign (RV32I encoding)
- alu_result_i  in  DATA_WIDTH  effective address or ALU result
- store_data_i  in  DATA_WIDTH  rs2 value
- rd_i, reg_write_i, mem_to_reg_i  in  RADDR_WIDTH/1/1  writeback control
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  DATA_WIDTH  word address (bits [1:0] = 0)
- dbus_wstrb_o  out  4  byte enables
- dbus_wdata_o  out  DATA_WIDTH  lane-aligned store data
- dbus_ack_i  in  1  access done
- dbus_rdata_i  in  DATA_WIDTH  read word, valid with ack
- rd_o, reg_write_o, mem_to_reg_o, alu_result_o  out  to MEM/WB
- load_data_o  out  DATA_WIDTH  extended load result
- stall_o  out  1  freeze PC/IF/ID/EX and EX/MEM
- misalign_o  out  1  misaligned address or illegal funct3
- bus_err_o  out  1  timeout abort pulse

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - A valid access (mem_read_i or mem_write_i, aligned, legal funct3) raises stall_o combinationally.
  - The bus fields are registered and the FSM moves to REQ.
  - A non-access passes the ctrl/data fields straight through, with stall_o=0.
- **REQ**
  - dbus_req_o=1; addr/we/wstrb/wdata are held stable; stall_o=1; reg_write_o=0 (bubble).
  - On dbus_ack_i=1 the FSM latches rdata and moves to RESP.
- **RESP**
  - stall_o=0; the original ctrl fields pass through; load_data_o is valid.
  - The FSM always returns to IDLE next cycle.
- **Load extraction** (byte lane = addr[1:0]):
  - LB 000: sign-extend byte.
  - LH 001: sign-extend half at addr[1].
  - LW 010: full word.
  - LBU 100 / LHU 101: zero-extend byte / half.
- **Store lanes:**
  - SB: wstrb = 4'b0001<<addr[1:0], data = byte replicated ×4.
  - SH: wstrb = 4'b0011<<{addr[1],1'b0}, data = half replicated ×2.
  - SW: wstrb = 4'b1111.
  - Loads drive wstrb = 0.
- **Misalignment / illegal funct3:**
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Illegal funct3 means load 011/110/111, or store ≥011.
  - Response: no bus request, misalign_o=1 for that cycle, reg_write_o=0, stall_o=0.
- Both mem_read_i and mem_write_i high is treated as a store.
- dbus_ack_i is ignored while dbus_req_o=0.

## Timing
- **Reset values:**
  - State IDLE.
  - dbus_req_o, dbus_we_o, misalign_o, bus_err_o, stall_o = 0.
  - dbus_addr_o, dbus_wdata_o, load_data_o = 0; dbus_wstrb_o = 0.
  - rd_o = 0, reg_write_o = 0, mem_to_reg_o = 0.
- **Access in cycle 0:**
  - stall_o=1 in cycle 0.
  - req rises at cycle 1.
  - With ack at cycle k (k≥1), RESP is at k+1, where stall_o=0 and MEM/WB captures the result.
  - Minimum load/store penalty: 2 stall cycles.
- dbus_req_o drops in the cycle after ack is sampled; there is never a back-to-back request without an intervening IDLE cycle.
- Reset asserted mid-access: state→IDLE and req=0 immediately (async). A late ack is ignored.

## Configuration
- **DBUS_TIMEOUT_EN defined:**
  - A counter clears on entering REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES−1 with no ack, the unit does the following:
    - deasserts req
    - pulses bus_err_o for one cycle
    - forces reg_write_o=0
    - returns to IDLE with stall_o=0
  - Ack in the same cycle as the limit wins, and no error is raised.
- **DBUS_TIMEOUT_EN undefined:** REQ waits indefinitely; bus_err_o is tied 0; the counter is absent.

## Test plan
- Directed scenarios; loads return rdata=0x8080_7F01, and each load result is checked at RESP.
  - LB addr 0x...03 with ack at cycle 1 → load_data_o=0xFFFF_FF80, stall_o high for exactly 2 cycles, wstrb=0.
  - LHU addr 0x...02 → 0x0000_8080.
  - SB addr 0x...01, store_data=0x0000_00AB, ack after 4 wait cycles → wstrb=4'b0010, wdata=0xABAB_ABAB, addr[1:0]=0, fields stable all REQ cycles, reg_write_o=0 until RESP.
  - LW addr 0x...02 → misalign_o=1 one cycle, no req, stall_o=0, reg_write_o=0. funct3=011 store → same response.
  - Non-memory ADD result 0x1234 with reg_write_i=1 → passes through the same cycle, stall_o=0, no bus activity.
  - rst_n low in the middle of REQ → req=0 immediately; an ack after reset release has no effect.
  - With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never arrives → bus_err_o pulses once, at the 8th REQ cycle, then IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage load/store unit of the rv32i pipeline.
// Drives a req/ack data bus and generates byte strobes and lane-aligned store
// data. Loads are sign/zero-extended. The upstream pipeline is stalled until
// the access completes. Non-memory instructions pass through with zero latency.
// Optional feature: define DBUS_TIMEOUT_EN to abort an access whose ack has
// not arrived within TIMEOUT_CYCLES REQ cycles. The abort pulses bus_err_o.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int RADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic [2:0]             funct3_i,
  input  logic [DATA_WIDTH-1:0]  alu_result_i,
  input  logic [DATA_WIDTH-1:0]  store_data_i,
  input  logic [RADDR_WIDTH-1:0] rd_i,
  input  logic                   reg_write_i,
  input  logic                   mem_to_reg_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [DATA_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_wstrb_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_ack_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic [RADDR_WIDTH-1:0] rd_o,
  output logic                   reg_write_o,
  output logic                   mem_to_reg_o,
  output logic [DATA_WIDTH-1:0]  alu_result_o,
  output logic [DATA_WIDTH-1:0]  load_data_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic                   bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Fields captured when the access is accepted, held for REQ and RESP.
  logic [1:0]             off_q;
  logic [2:0]             f3_q;
  logic [RADDR_WIDTH-1:0] rd_q;
  logic                   rw_q;
  logic                   m2r_q;
  logic [DATA_WIDTH-1:0]  alu_q;

  logic                   access;
  logic                   illegal;
  logic                   misaligned;
  logic                   valid_access;
  logic [3:0]             wstrb_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [DATA_WIDTH-1:0]  load_ext;
  logic                   tmo_hit;

  assign dbus_req_o = (state_q == S_REQ);

  // Classify the incoming instruction: access request, legality and alignment.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    access     = mem_read_i | mem_write_i;
    illegal    = 1'b0;
    misaligned = 1'b0;
    // A store wins when both request lines are high.
    if (mem_write_i) begin
      illegal = (funct3_i >= 3'b011);
    end else begin
      illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    end
    case (funct3_i[1:0])
      2'b01:   misaligned = alu_result_i[0];
      2'b10:   misaligned = (alu_result_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    valid_access = access & ~illegal & ~misaligned;
  end

  // Store lane steering: byte/half replicated across the word, strobes shifted.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = store_data_i;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << alu_result_i[1:0];
          wdata_d = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << {alu_result_i[1], 1'b0};
          wdata_d = {2{store_data_i[15:0]}};
        end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  // Load extraction from the returned word using the captured lane and size.
  always_comb begin
    byte_sel = dbus_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = dbus_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_ext = dbus_rdata_i;
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == S_REQ) && !dbus_ack_i &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles without ack; cleared whenever the FSM is outside REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_REQ) begin
      tmo_cnt_q <= '0;
    end else if (!dbus_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the bus fields on acceptance and the extended load word on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wstrb_o <= 4'b0000;
      dbus_wdata_o <= '0;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      m2r_q        <= 1'b0;
      alu_q        <= '0;
      load_data_o  <= '0;
    end else begin
      if (state_q == S_IDLE && valid_access) begin
        dbus_we_o    <= mem_write_i;
        dbus_addr_o  <= {alu_result_i[DATA_WIDTH-1:2], 2'b00};
        dbus_wstrb_o <= wstrb_d;
        dbus_wdata_o <= wdata_d;
        off_q        <= alu_result_i[1:0];
        f3_q         <= funct3_i;
        rd_q         <= rd_i;
        rw_q         <= reg_write_i;
        m2r_q        <= mem_to_reg_i;
        alu_q        <= alu_result_i;
      end
      if (dbus_req_o && dbus_ack_i && !dbus_we_o) begin
        load_data_o <= load_ext;
      end
    end
  end

  // Next-state logic plus stall / writeback-control outputs.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    rd_o         = rd_i;
    reg_write_o  = reg_write_i;
    mem_to_reg_o = mem_to_reg_i;
    alu_result_o = alu_result_i;
    case (state_q)
      S_IDLE: begin
        if (valid_access) begin
          stall_o     = 1'b1;
          reg_write_o = 1'b0;
          state_d     = S_REQ;
        end else if (access) begin
          misalign_o  = 1'b1;
          reg_write_o = 1'b0;
        end
      end
      S_REQ: begin
        stall_o      = 1'b1;
        rd_o         = rd_q;
        reg_write_o  = 1'b0;
        mem_to_reg_o = m2r_q;
        alu_result_o = alu_q;
        if (dbus_ack_i) begin
          state_d = S_RESP;
        end else if (tmo_hit) begin
          stall_o   = 1'b0;
          bus_err_o = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RESP: begin
        rd_o         = rd_q;
        reg_write_o  = rw_q;
        mem_to_reg_o = m2r_q;
        alu_result_o = alu_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
